mult_div: RTL
=============

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL expose parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port: clock  in  1  system clock; all state changes on rising edge.
REQ-003 The block SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: start  in  1  request a new operation.
REQ-005 The block SHALL have port: op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have port: operand_a  in  32  rs value, driven from register-file ReadData1.
REQ-007 The block SHALL have port: operand_b  in  32  rt value, driven from register-file ReadData2.
REQ-008 The block SHALL have port: write_hi  in  1  MTHI strobe.
REQ-009 The block SHALL have port: write_lo  in  1  MTLO strobe.
REQ-010 The block SHALL have port: write_data  in  32  data for MTHI/MTLO.
REQ-011 The block SHALL have port: busy  out  1  operation in progress.
REQ-012 The block SHALL have port: done  out  1  one-cycle result-valid pulse.
REQ-013 The block SHALL have port: hi  out  32  HI register (product high word / remainder); feeds register-file WriteData via MFHI.
REQ-014 The block SHALL have port: lo  out  32  LO register (product low word / quotient); feeds WriteData via MFLO.

Function
REQ-015 The block SHALL implement states IDLE and CALC; busy=1 exactly when state is CALC; hi/lo/done are registered outputs.
REQ-016 In IDLE, start=1 at rising edge N SHALL latch operand_a, operand_b, op, clear the 5-bit iteration counter, and enter CALC.
REQ-017 Operands SHALL be used only from the copy latched at edge N; later changes on operand_a/operand_b SHALL have no effect.
REQ-018 CALC SHALL perform one iteration per clock (shift-add for multiply, restoring shift-subtract for divide) for exactly 32 edges, N+1..N+32.
REQ-019 At edge N+32 the block SHALL load hi/lo with the result, return to IDLE, set busy=0 and done=1; done SHALL return to 0 at edge N+33 unless a new result completes.
REQ-020 start while in CALC SHALL be ignored (no queuing); start in the done cycle (IDLE) SHALL be accepted as a new operation.
REQ-021 Signed ops SHALL compute on magnitudes, then negate: product if operand signs differ; quotient if signs differ; remainder takes the dividend's sign.
REQ-022 MULT/MULTU: {hi,lo} = full 64-bit product.
REQ-023 DIV/DIVU: lo = quotient, hi = remainder, quotient truncated toward zero.
REQ-024 Divide by zero (either divide op): hi = latched operand_a, lo = 32'hFFFFFFFF, same 32-cycle latency, done pulses normally.
REQ-025 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo = 32'h80000000, hi = 0.
REQ-026 write_hi/write_lo in IDLE SHALL update hi/lo with write_data at that edge; both may be asserted together.
REQ-027 write_hi/write_lo while in CALC, including at edge N+32, SHALL be ignored.
REQ-028 write_hi/write_lo and start asserted together in IDLE SHALL perform the write and start the operation; the completed result later overwrites hi/lo.
REQ-029 hi/lo SHALL hold their value at all times other than REQ-019 and REQ-026 events.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of state.
REQ-031 reset SHALL take priority over start, write_hi and write_lo in the same cycle.
REQ-032 Reset during CALC SHALL abort the operation; no done pulse and no hi/lo update SHALL follow.

Verification
REQ-033 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF, start at edge N -> busy=1 for edges N..N+31; at edge N+32: hi=32'hFFFFFFFE, lo=32'h00000001, done=1 for one cycle.
REQ-034 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Back-to-back start in the done cycle: MULT 0 x 5 -> hi=lo=0 exactly 32 edges later.
REQ-035 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
REQ-036 DIVU 100 / 0 -> hi=32'h00000064, lo=32'hFFFFFFFF, done at N+32. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-037 Start DIVU 9/3, change operands at N+1, pulse start at N+5, assert reset at N+10 -> operand change and second start ignored; after reset: busy=0, hi=lo=0, no done in the following 40 cycles.
REQ-038 write_lo=1, write_data=32'h12345678 in IDLE -> lo=32'h12345678 next cycle. write_hi=1 during CALC -> hi unchanged.

Source files
------------

// File: rtl/mult_div_if.sv
// Bundle of the request, HI/LO write and result signals shared between the
// pipeline control (master) and the multiply/divide unit (slave).
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div.sv
// Iterative MIPS-style HI/LO unit: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied when loading HI/LO.
module mult_div #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  mult_div_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_next;
  logic [4:0]       count;
  logic             is_div, neg_q, neg_r;
  logic [WIDTH-1:0] a_raw, b_mag, acc_hi, acc_lo;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;
  logic             last_iter;

  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   iter_hi, iter_lo;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign bus.busy  = (state == CALC);
  assign bus.done  = done_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign last_iter = (state == CALC) && (count == 5'd31);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // op[0] marks the signed variants; only those take magnitudes.
  always_comb begin
    a_neg_in = bus.op[0] & bus.operand_a[WIDTH-1];
    b_neg_in = bus.op[0] & bus.operand_b[WIDTH-1];
    a_mag_in = a_neg_in ? -bus.operand_a : bus.operand_a;
    b_mag_in = b_neg_in ? -bus.operand_b : bus.operand_b;
  end

  // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_mag;
    div_ge    = div_shift >= {1'b0, b_mag};
    if (is_div) begin
      iter_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      iter_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    product = {iter_hi, iter_lo};
    if (neg_q) product = -product;
    res_hi = product[2*WIDTH-1:WIDTH];
    res_lo = product[WIDTH-1:0];
    if (is_div) begin
      if (b_mag == '0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -iter_hi : iter_hi;
        res_lo = neg_q ? -iter_lo : iter_lo;
      end
    end
  end

  // Writes are honoured only in IDLE; a start in the same cycle still launches.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      a_raw    <= '0;
      b_mag    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state == IDLE) begin
        if (bus.write_hi) hi_reg <= bus.write_data;
        if (bus.write_lo) lo_reg <= bus.write_data;
        if (bus.start) begin
          count  <= '0;
          a_raw  <= bus.operand_a;
          b_mag  <= b_mag_in;
          acc_hi <= '0;
          acc_lo <= a_mag_in;
          is_div <= bus.op[1];
          neg_q  <= a_neg_in ^ b_neg_in;
          neg_r  <= a_neg_in;
        end
      end else begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        count  <= count + 5'd1;
        if (last_iter) begin
          hi_reg   <= res_hi;
          lo_reg   <= res_lo;
          done_reg <= 1'b1;
        end
      end
    end
  end

endmodule
